mult_demo_ctrl: RTL and testbench

//  Parametrised successor to the key-driven multiplier demo top: mode FSM, manual and auto operand entry,

---
 rtl/mult_demo_pkg.sv | 22 ++
 rtl/seq_mult.sv | 75 +++++++
 rtl/mult_demo_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mult_demo_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_demo_pkg.sv
// Shared definitions for the multiplier demo controller.
//   state_t : controller FSM states, encodings visible on state_o
//   K_*     : bit positions within the debounced active-low key bus
package mult_demo_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_BANNER = 3'd1,
    S_ENTRY  = 3'd2,
    S_CALC   = 3'd3,
    S_RESULT = 3'd4,
    S_AUTO   = 3'd5
  } state_t;

  localparam int unsigned K_MODE  = 0;
  localparam int unsigned K_INC_A = 1;
  localparam int unsigned K_INC_B = 2;
  localparam int unsigned K_CALC  = 3;
  localparam int unsigned K_AUTO  = 4;
  localparam int unsigned NKEYS   = 5;

endpackage

// File: rtl/seq_mult.sv
// Sequential shift-add W x W unsigned multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous abort, returns to idle with product cleared
//   start      : latch a/b and begin; must not be asserted while busy
//   a, b       : operands
//   product    : 2W-bit result, valid with done and held until next start
//   done       : one-cycle pulse W cycles after start
//   busy       : high from start+1 through start+W
module seq_mult #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done,
  output logic           busy
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q;

  // Bit 0 is consumed on the start edge so the last partial product lands
  // one cycle early; the final busy cycle (cnt_q == W) carries the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clr) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= b[0] ? (2*W)'(a) : '0;
      mcand_q  <= (2*W)'(a) << 1;
      mplier_q <= b >> 1;
      cnt_q    <= CW'(1);
      busy_q   <= 1'b1;
      done_q   <= (W == 1);
    end else if (busy_q) begin
      if (cnt_q == CW'(W)) begin
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        done_q   <= (cnt_q == CW'(W - 1));
      end
    end
  end

  assign product = acc_q;
  assign done    = done_q;
  assign busy    = busy_q;

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) start |-> !busy_q)
    else $error("seq_mult: start asserted while busy");

endmodule

// File: rtl/mult_demo_ctrl.sv
// Key-driven multiplier demo controller: mode FSM, manual and auto operand
// entry, sequential multiply, hex display word and LED-chaser enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : debounced active-low keys [0]mode [1]inc_a [2]inc_b [3]calc [4]auto
//   number     : DIGITS*4-bit display word, hex nibbles MSD first
//   led_en     : LED chaser enable (BANNER only)
//   busy       : multiplier running
//   state_o    : registered FSM state encoding
// Build option: define AUTO_MODE_EN to include the S_AUTO stepping mode;
// without it the auto key is ignored everywhere.
module mult_demo_ctrl
  import mult_demo_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned DIGITS     = 6,
  parameter              BANNER     = 24'h332002,
  parameter int unsigned AUTO_TICKS = 25000000,
  parameter int unsigned AUTO_A0    = 1,
  parameter int unsigned AUTO_B0    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NKEYS-1:0]      key_n,
  output logic [DIGITS*4-1:0]   number,
  output logic                  led_en,
  output logic                  busy,
  output logic [2:0]            state_o
);

  localparam int unsigned NW = DIGITS * 4;
  localparam logic [NW-1:0] BANNER_W = NW'(BANNER);

  if (NW < 2 * W) begin : g_width_check
    $error("mult_demo_ctrl: DIGITS*4 must be >= 2*W");
  end

  function automatic logic [NW-1:0] pair_word(input logic [W-1:0] x, input logic [W-1:0] y);
    pair_word = '0;
    pair_word[NW-1 -: 2*W] = {x, y};
  endfunction

  logic [NKEYS-1:0] key_q, press;
  state_t           state_q, state_d;
  logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [NW-1:0]    number_q, number_d;
  logic             led_q;

  logic             mul_start, mul_clr, mul_done, mul_busy;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   product;

  // Falling edge of a released key: one event per press.
  assign press = key_q & ~key_n;

`ifdef AUTO_MODE_EN
  localparam int unsigned TW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  logic [W-1:0]  auto_a_q, auto_a_d, auto_b_q, auto_b_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          show_prod_q, show_prod_d;
`else
  logic auto_key_unused;
  assign auto_key_unused = press[K_AUTO];
`endif

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mul_start = 1'b0;
    mul_clr   = 1'b0;
    mul_a     = op_a_q;
    mul_b     = op_b_q;
`ifdef AUTO_MODE_EN
    auto_a_d    = auto_a_q;
    auto_b_d    = auto_b_q;
    tick_d      = tick_q;
    show_prod_d = show_prod_q;
`endif
    case (state_q)
      S_RST: if (press[K_MODE]) state_d = S_BANNER;
      S_BANNER, S_RESULT: begin
        if (press[K_MODE]) begin
          state_d = S_RST;
`ifdef AUTO_MODE_EN
        end else if (press[K_AUTO]) begin
          state_d     = S_AUTO;
          tick_d      = '0;
          show_prod_d = 1'b0;
          mul_start   = 1'b1;
          mul_a       = auto_a_q;
          mul_b       = auto_b_q;
`endif
        end else if (press[K_CALC] && state_q == S_RESULT) begin
          state_d   = S_CALC;
          mul_start = 1'b1;
        end else if (press[K_INC_A] || press[K_INC_B]) begin
          state_d = S_ENTRY;
          op_a_d  = op_a_q + W'(press[K_INC_A]);
          op_b_d  = op_b_q + W'(press[K_INC_B]);
        end
      end
      S_ENTRY: begin
        if (press[K_MODE]) begin
          state_d = S_RST;
        end else if (press[K_CALC]) begin
          state_d   = S_CALC;
          mul_start = 1'b1;
        end else begin
          op_a_d = op_a_q + W'(press[K_INC_A]);
          op_b_d = op_b_q + W'(press[K_INC_B]);
        end
      end
      S_CALC: begin
        if (press[K_MODE]) begin
          state_d = S_RST;
          mul_clr = 1'b1;
        end else if (mul_done) begin
          state_d = S_RESULT;
        end
      end
`ifdef AUTO_MODE_EN
      S_AUTO: begin
        // Leaving auto mode aborts any step in flight so a later calc never
        // collides with a running multiply.
        if (press[K_MODE]) begin
          state_d = S_RST;
          mul_clr = 1'b1;
        end else if (press[K_AUTO]) begin
          state_d = S_BANNER;
          mul_clr = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
          if (mul_done) show_prod_d = 1'b1;
          if (tick_q == TW'(AUTO_TICKS - 1)) begin
            tick_d      = '0;
            auto_a_d    = auto_a_q + W'(1);
            auto_b_d    = auto_b_q + W'(1);
            show_prod_d = 1'b0;
            mul_start   = 1'b1;
            mul_a       = auto_a_d;
            mul_b       = auto_b_d;
          end
        end
      end
`endif
      default: state_d = S_RST;
    endcase
  end

  // Display word follows the next state so it updates together with state_o.
  always_comb begin
    number_d = '0;
    case (state_d)
      S_BANNER: number_d = BANNER_W;
      S_ENTRY:  number_d = pair_word(op_a_d, op_b_d);
      S_CALC:   number_d = number_q;
      S_RESULT: number_d = NW'(product);
`ifdef AUTO_MODE_EN
      S_AUTO:   number_d = show_prod_d ? NW'(product) : pair_word(auto_a_d, auto_b_d);
`endif
      default:  number_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '1;
      state_q  <= S_RST;
      op_a_q   <= '0;
      op_b_q   <= '0;
      number_q <= '0;
      led_q    <= 1'b0;
`ifdef AUTO_MODE_EN
      auto_a_q    <= W'(AUTO_A0);
      auto_b_q    <= W'(AUTO_B0);
      tick_q      <= '0;
      show_prod_q <= 1'b0;
`endif
    end else begin
      key_q    <= key_n;
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      number_q <= number_d;
      led_q    <= (state_d == S_BANNER);
`ifdef AUTO_MODE_EN
      auto_a_q    <= auto_a_d;
      auto_b_q    <= auto_b_d;
      tick_q      <= tick_d;
      show_prod_q <= show_prod_d;
`endif
    end
  end

  seq_mult #(.W(W)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mul_clr),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .product (product),
    .done    (mul_done),
    .busy    (mul_busy)
  );

  assign number  = number_q;
  assign led_en  = led_q;
  assign busy    = mul_busy;
  assign state_o = state_q;

endmodule

// File: tb/tb_mult_demo_ctrl.sv
module tb_mult_demo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  key_n;
  logic [23:0] number;
  logic        led_en, busy;
  logic [2:0]  state_o;

  localparam logic [4:0] MODE = 5'b00001;
  localparam logic [4:0] INCA = 5'b00010;
  localparam logic [4:0] INCB = 5'b00100;
  localparam logic [4:0] CALC = 5'b01000;
  localparam logic [4:0] AUTO = 5'b10000;

  always #5 clk = ~clk;

  mult_demo_ctrl #(
    .W(8), .DIGITS(6), .BANNER(24'h332002), .AUTO_TICKS(20), .AUTO_A0(1), .AUTO_B0(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .number(number),
    .led_en(led_en), .busy(busy), .state_o(state_o)
  );

  typedef struct {
    logic [23:0] num;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] ma, mb;
  int   n;

  task automatic expect_out(input logic [23:0] num, input logic [2:0] st);
    exp_t t;
    t.num = num;
    t.st  = st;
    sb.push_back(t);
  endtask

  function automatic logic [23:0] entry_word(input logic [7:0] a, input logic [7:0] b);
    return {a, b, 8'h00};
  endfunction

  // One-cycle key press; returns at the negedge after the FSM has reacted.
  task automatic press(input logic [4:0] m);
    @(posedge clk); #1 key_n = key_n & ~m;
    @(posedge clk); #1 key_n = key_n | m;
    @(negedge clk);
  endtask

  task automatic wait_change(input logic [23:0] prev, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (number === prev && cyc < 100);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_n = '1;
    ma = 8'h00; mb = 8'h00;
    repeat (3) @(negedge clk);
    expect_out(24'h0, 3'd0);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st || led_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: number=%h state=%0d led=%b busy=%b, want %h %0d 0 0", number, state_o, led_en, busy, e.num, e.st);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_banner;
    expect_out(24'h332002, 3'd1);
    press(MODE);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st || led_en !== 1'b1) begin
      miscompares++;
      $display("FAIL banner_enter: number=%h state=%0d led=%b, want %h %0d 1", number, state_o, led_en, e.num, e.st);
    end
    expect_out(24'h0, 3'd0);
    press(MODE);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st || led_en !== 1'b0) begin
      miscompares++;
      $display("FAIL banner_exit: number=%h state=%0d led=%b, want %h %0d 0", number, state_o, led_en, e.num, e.st);
    end
  endtask

  task automatic test_calc;
    press(MODE);
    for (int i = 0; i < 3; i++) begin press(INCA); ma++; end
    for (int i = 0; i < 5; i++) begin press(INCB); mb++; end
    expect_out(entry_word(ma, mb), 3'd2);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL entry_3_5: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    expect_out(entry_word(ma, mb), 3'd3);
    press(CALC);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL calc_hold: number=%h state=%0d busy=%b, want %h %0d 1", number, state_o, busy, e.num, e.st);
    end
    expect_out(24'(ma * mb), 3'd4);
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (n !== 8) begin
      miscompares++;
      $display("FAIL busy_len: got %0d cycles, want 8", n);
    end
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL result_3x5: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
  endtask

  task automatic test_wrap;
    press(MODE); press(MODE);
    while (ma != 8'hFF) begin press(INCA); ma++; end
    expect_out(entry_word(ma, mb), 3'd2);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL op_a_ff: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    press(INCA); ma++;
    expect_out(entry_word(ma, mb), 3'd2);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL op_a_wrap: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    while (ma != 8'hFF) begin press(INCA); ma++; end
    while (mb != 8'hFF) begin press(INCB); mb++; end
    press(CALC);
    expect_out(24'h00FE01, 3'd4);
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL result_ffxff: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
  endtask

  task automatic test_same_cycle;
    press(INCB); mb++;
    expect_out(24'h0, 3'd0);
    press(INCA | MODE);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL mode_over_inc: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    press(MODE);
    press(INCB); mb++;
    expect_out(entry_word(ma, mb), 3'd2);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL op_a_kept: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    // Hold inc_a for 100 cycles: exactly one increment.
    @(posedge clk); #1 key_n = key_n & ~INCA;
    ma++;
    expect_out(entry_word(ma, mb), 3'd2);
    repeat (100) @(posedge clk);
    #1 key_n = key_n | INCA;
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL held_key: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) begin press(INCA); ma++; end
    for (int i = 0; i < 6; i++) begin press(INCB); mb++; end
    press(CALC);
    @(posedge clk); @(posedge clk); #1 key_n = key_n & ~MODE;
    @(posedge clk); #1 key_n = key_n | MODE;
    @(negedge clk);
    expect_out(24'h0, 3'd0);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: number=%h state=%0d busy=%b, want %h %0d 0", number, state_o, busy, e.num, e.st);
    end
    press(MODE);
    press(INCA); ma++;
    press(CALC);
    expect_out(24'(ma * mb), 3'd4);
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (n !== 8) begin
      miscompares++;
      $display("FAIL busy_len_after_abort: got %0d cycles, want 8", n);
    end
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL result_after_abort: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
  endtask

`ifdef AUTO_MODE_EN
  task automatic test_auto;
    logic [23:0] want [4];
    int          gap  [4];
    want[0] = 24'h010200; want[1] = 24'h000002; want[2] = 24'h020300; want[3] = 24'h000006;
    gap[1] = 8; gap[2] = 12; gap[3] = 8;
    press(MODE); press(MODE);
    for (int i = 0; i < 4; i++) expect_out(want[i], 3'd5);
    press(AUTO);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL auto_entry: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    for (int i = 1; i < 4; i++) begin
      wait_change(want[i-1], n);
      e = sb.pop_front();
      vectors++;
      if (number !== e.num || state_o !== e.st || n !== gap[i]) begin
        miscompares++;
        $display("FAIL auto_step%0d: number=%h state=%0d after %0d cycles, want %h %0d after %0d", i, number, state_o, n, e.num, e.st, gap[i]);
      end
    end
    expect_out(24'h332002, 3'd1);
    press(AUTO);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st || led_en !== 1'b1) begin
      miscompares++;
      $display("FAIL auto_exit: number=%h state=%0d led=%b, want %h %0d 1", number, state_o, led_en, e.num, e.st);
    end
  endtask
`else
  task automatic test_no_auto;
    expect_out(24'(ma * mb), 3'd4);
    press(AUTO);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL auto_ignored_result: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
    press(MODE); press(MODE);
    expect_out(24'h332002, 3'd1);
    press(AUTO);
    e = sb.pop_front();
    vectors++;
    if (number !== e.num || state_o !== e.st) begin
      miscompares++;
      $display("FAIL auto_ignored_banner: number=%h state=%0d, want %h %0d", number, state_o, e.num, e.st);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_banner();
    test_calc();
    test_wrap();
    test_same_cycle();
    test_abort();
`ifdef AUTO_MODE_EN
    test_auto();
`else
    test_no_auto();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
